// File: rtl/data_pkg.sv
// Shared definitions for the frame reader: state encoding, default header bytes
// and header length.
package data_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_DATA = 3'd2,
        ST_SUM  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;
    localparam int         HDR_LEN   = 5;

endpackage

// File: rtl/data_read_fifo.sv
// Two-entry byte skid FIFO between the RAM read port and the transmit register.
module data_read_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    // A push into a full FIFO is accepted only when the same edge frees a slot.
    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/data_read.sv
// Reads a payload from RAM port B and streams it as a framed byte sequence
// (header, payload, 8-bit checksum) over a valid/ready transmitter link.
module data_read
    import data_pkg::*;
#(
    parameter logic [7:0] HEAD0 = HEAD0_DEF,
    parameter logic [7:0] HEAD1 = HEAD1_DEF,
    parameter int         AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs,
    output logic          fd,
    input  logic [3:0]    btype,
    input  logic [AW-1:0] ram_addr_init,
    input  logic [11:0]   ram_dlen,
    output logic [AW-1:0] ram_rxa,
    input  logic [7:0]    ram_rxd,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [2:0]    dbg_state_o
);

    localparam logic [11:0] HdrLast = 12'(HDR_LEN - 1);

    state_e        state_q;
    logic [3:0]    btype_q;
    logic [11:0]   dlen_q;
    logic [AW-1:0] ram_rxa_q;
    logic [11:0]   rd_cnt_q;
    logic [11:0]   cnt_q;
    logic [7:0]    sum_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic          fd_q;
    logic          pend_q;

    logic          xfer;
    logic          pop;
    logic          issue;
    logic          last_pay;
    logic [1:0]    fifo_cnt;
    logic [1:0]    occ;
    logic [7:0]    sum_d;
    logic [7:0]    hdr_d;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    data_read_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pend_q),
        .pop_i   (pop),
        .din_i   (ram_rxd),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Handshake: a byte moves when tx_valid and tx_ready are both high at a
    // rising edge; tx_data is held unchanged while tx_valid waits for ready.
    always_comb begin
        xfer     = tx_valid_q && tx_ready;
        fifo_cnt = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
        occ      = fifo_cnt + {1'b0, pend_q};
        last_pay = (cnt_q + 12'd1) == dlen_q;
        sum_d    = sum_q + tx_data_q;
        pop      = 1'b0;
        case (state_q)
            ST_HEAD: pop = xfer && (cnt_q == HdrLast) && (dlen_q != 12'd0) && !fifo_empty;
            ST_DATA: pop = !fifo_empty && (xfer ? !last_pay : !tx_valid_q);
            default: pop = 1'b0;
        endcase
        // The in-flight read counts against FIFO room; a same-edge pop frees one.
        issue = ((state_q == ST_HEAD) || (state_q == ST_DATA)) &&
                (rd_cnt_q != dlen_q) && ((occ < 2'd2) || pop);
        case (cnt_q[1:0])
            2'd0:    hdr_d = HEAD1;
            2'd1:    hdr_d = {4'h0, btype_q};
            2'd2:    hdr_d = {4'h0, dlen_q[11:8]};
            default: hdr_d = dlen_q[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            btype_q    <= '0;
            dlen_q     <= '0;
            ram_rxa_q  <= '0;
            rd_cnt_q   <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            fd_q       <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            pend_q <= issue;
            if (issue) begin
                ram_rxa_q <= ram_rxa_q + AW'(1);
                rd_cnt_q  <= rd_cnt_q + 12'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (fs) begin
                        state_q    <= ST_HEAD;
                        btype_q    <= btype;
                        dlen_q     <= ram_dlen;
                        ram_rxa_q  <= ram_addr_init;
                        rd_cnt_q   <= '0;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        tx_data_q  <= HEAD0;
                        tx_valid_q <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (xfer) begin
                        if (cnt_q == HdrLast) begin
                            cnt_q <= '0;
                            if (dlen_q == 12'd0) begin
                                tx_data_q <= sum_q;
                                state_q   <= ST_SUM;
                            end else begin
                                state_q    <= ST_DATA;
                                tx_data_q  <= fifo_dout;
                                tx_valid_q <= pop;
                            end
                        end else begin
                            cnt_q     <= cnt_q + 12'd1;
                            tx_data_q <= hdr_d;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        sum_q <= sum_d;
                        cnt_q <= cnt_q + 12'd1;
                        if (last_pay) begin
                            tx_data_q <= sum_d;
                            state_q   <= ST_SUM;
                        end else begin
                            tx_data_q  <= fifo_dout;
                            tx_valid_q <= pop;
                        end
                    end else if (pop) begin
                        tx_data_q  <= fifo_dout;
                        tx_valid_q <= 1'b1;
                    end
                end
                ST_SUM: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        fd_q       <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!fs) begin
                        fd_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fd          = fd_q;
    assign ram_rxa     = ram_rxa_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign dbg_state_o = state_q;

endmodule
